mdu_ctrl: RTL

//  Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits beside the ALU in EX.

---
 rtl/mdu_ctrl_pkg.sv | 41 ++++
 rtl/mdu_arith.sv | 96 +++++++++
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared md_op encodings, FSM states and default latencies for the MDU.
// MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU multi-cycle ops; otherwise they are NOPs.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU)
              || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: (op, a, b, hi, lo) -> {new_hi, new_lo, write_en}.
// MDU_MADD_EN adds the multiply-accumulate/subtract ops on the {hi,lo} accumulator.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_we
);

    logic [63:0] w_sa;
    logic [63:0] w_sb;
    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sdsor;
    logic [31:0] w_udsor;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic        w_bzero;

    assign w_sa    = {{32{i_a[31]}}, i_a};
    assign w_sb    = {{32{i_b[31]}}, i_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    // Sign-magnitude divide; INT_MIN/-1 falls out as 0x80000000 rem 0.
    assign w_bzero  = (i_b == 32'd0);
    assign w_abs_a  = i_a[31] ? -i_a : i_a;
    assign w_abs_b  = i_b[31] ? -i_b : i_b;
    assign w_sdsor  = w_bzero ? 32'd1 : w_abs_b;
    assign w_udsor  = w_bzero ? 32'd1 : i_b;
    assign w_sq_mag = w_abs_a / w_sdsor;
    assign w_sr_mag = w_abs_a % w_sdsor;
    assign w_sq     = (i_a[31] ^ i_b[31]) ? -w_sq_mag : w_sq_mag;
    assign w_sr     = i_a[31] ? -w_sr_mag : w_sr_mag;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`endif

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        o_we = 1'b0;
        case (i_op)
            MD_MULT: begin
                {o_hi, o_lo} = w_sprod;
                o_we = 1'b1;
            end
            MD_MULTU: begin
                {o_hi, o_lo} = w_uprod;
                o_we = 1'b1;
            end
            MD_DIV: begin
                o_lo = w_sq;
                o_hi = w_sr;
                o_we = !w_bzero;
            end
            MD_DIVU: begin
                o_lo = i_a / w_udsor;
                o_hi = i_a % w_udsor;
                o_we = !w_bzero;
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                {o_hi, o_lo} = w_acc + w_sprod;
                o_we = 1'b1;
            end
            MD_MADDU: begin
                {o_hi, o_lo} = w_acc + w_uprod;
                o_we = 1'b1;
            end
            MD_MSUB: begin
                {o_hi, o_lo} = w_acc - w_sprod;
                o_we = 1'b1;
            end
            MD_MSUBU: begin
                {o_hi, o_lo} = w_acc - w_uprod;
                o_we = 1'b1;
            end
`endif
            default: o_we = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU control: IDLE/RUN FSM, latency counter, operand latches and HI/LO registers.
// MDU_MADD_EN enables the MADD/MSUB family as multi-cycle ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_pending,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      r_state;
    state_e      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_latch;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_is_mul;
    logic        w_is_div;
    logic [31:0] w_new_hi;
    logic [31:0] w_new_lo;
    logic        w_we;

    assign w_is_mul = is_mul_op(md_op);
    assign w_is_div = is_div_op(md_op);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && w_is_mul) begin
                    w_latch      = 1'b1;
                    w_next_cnt   = 4'(MULT_CYCLES - 1);
                    w_next_state = S_RUN;
                end else if (start && w_is_div) begin
                    w_latch      = 1'b1;
                    w_next_cnt   = 4'(DIV_CYCLES - 1);
                    w_next_state = S_RUN;
                end else if (start) begin
                    w_mthi = (md_op == MD_MTHI);
                    w_mtlo = (md_op == MD_MTLO);
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd0) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 4'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
        end else if (w_latch) begin
            r_op <= md_op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    mdu_arith u_arith (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_new_hi),
        .o_lo (w_new_lo),
        .o_we (w_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit && w_we) begin
            r_hi <= w_new_hi;
            r_lo <= w_new_lo;
        end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign busy       = (r_state == S_RUN);
    assign md_pending = (start && (w_is_mul || w_is_div)) || busy;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
